// File: rtl/elevator_car_scheduler.sv
// rtl/elevator_car_scheduler.sv - single-car SCAN elevator scheduler with stepper sequencing and door dwell
// Optional emergency-stop freeze is compiled in with `define ESTOP_EN.
module elevator_car_scheduler #(
  parameter int NUM_FLOORS      = 9,
  parameter int STEP_CYCLES     = 240000,
  parameter int STEPS_PER_FLOOR = 512,
  parameter int DOOR_CYCLES     = 24000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_btns,
`ifdef ESTOP_EN
  input  logic                  estop,
`endif
  output logic                  motor_en,
  output logic                  motor_dir,
  output logic                  step_pulse,
  output logic [3:0]            cur_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open
);

  localparam int STW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int SCW = (STEPS_PER_FLOOR > 1) ? $clog2(STEPS_PER_FLOOR) : 1;
  localparam int DTW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t                state;
  logic [NUM_FLOORS-1:0] prev_btns;
  logic [STW-1:0]        step_timer;
  logic [SCW-1:0]        step_cnt;
  logic [DTW-1:0]        door_timer;

  logic                  halt;
  logic [NUM_FLOORS-1:0] edges;
  logic [NUM_FLOORS-1:0] cur_bit;
  logic [NUM_FLOORS-1:0] next_bit;
  logic [NUM_FLOORS-1:0] mask_edges;
  logic [NUM_FLOORS-1:0] clr_mask;
  logic [NUM_FLOORS-1:0] pending_d;
  logic [3:0]            next_floor;
  logic                  any_above;
  logic                  any_below;
  logic                  step_wrap;
  logic                  floor_done;
  logic                  stop_here;
  logic                  door_restart;
  logic                  door_done;

`ifdef ESTOP_EN
  assign halt = estop;
`else
  assign halt = 1'b0;
`endif

  assign edges      = call_btns & ~prev_btns;
  assign cur_bit    = NUM_FLOORS'(1) << cur_floor;
  assign next_bit   = NUM_FLOORS'(1) << next_floor;
  assign step_wrap  = (step_timer == STW'(STEP_CYCLES - 1));
  assign floor_done = step_wrap && (step_cnt == SCW'(STEPS_PER_FLOOR - 1));
  assign door_done  = (door_timer == DTW'(DOOR_CYCLES - 1));

  always_comb begin
    next_floor = cur_floor;
    if (motor_dir && (cur_floor != 4'(NUM_FLOORS - 1)))
      next_floor = cur_floor + 4'd1;
    else if (!motor_dir && (cur_floor != 4'd0))
      next_floor = cur_floor - 4'd1;
  end

  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i > int'(cur_floor))) any_above = 1'b1;
      if (pending[i] && (i < int'(cur_floor))) any_below = 1'b1;
    end
  end

  // An edge for the floor being arrived at counts as served: stop there, do not latch it.
  assign stop_here    = (state == MOVE) && !halt && floor_done && (|((pending | edges) & next_bit));
  assign door_restart = (state == DOOR) && (|(edges & cur_bit));

  always_comb begin
    mask_edges = '0;
    clr_mask   = '0;
    if (state == DOOR) mask_edges = cur_bit;
    if (stop_here) begin
      mask_edges = next_bit;
      clr_mask   = next_bit;
    end
    if ((state == IDLE) && !halt && (|(pending & cur_bit))) clr_mask = cur_bit;
    pending_d = (pending | (edges & ~mask_edges)) & ~clr_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prev_btns  <= '0;
      pending    <= '0;
      step_timer <= '0;
      step_cnt   <= '0;
      door_timer <= '0;
      cur_floor  <= 4'd0;
      motor_en   <= 1'b0;
      motor_dir  <= 1'b1;
      step_pulse <= 1'b0;
      door_open  <= 1'b0;
    end else begin
      prev_btns  <= call_btns;
      pending    <= pending_d;
      step_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (!halt) begin
            if (|(pending & cur_bit)) begin
              state      <= DOOR;
              door_open  <= 1'b1;
              door_timer <= '0;
            end else if (any_above && (motor_dir || !any_below)) begin
              motor_dir  <= 1'b1;
              motor_en   <= 1'b1;
              step_timer <= '0;
              step_cnt   <= '0;
              state      <= MOVE;
            end else if (any_below) begin
              motor_dir  <= 1'b0;
              motor_en   <= 1'b1;
              step_timer <= '0;
              step_cnt   <= '0;
              state      <= MOVE;
            end
          end
        end
        MOVE: begin
          if (halt) begin
            motor_en <= 1'b0;
          end else begin
            motor_en <= 1'b1;
            if (step_wrap) begin
              step_timer <= '0;
              step_pulse <= 1'b1;
              if (floor_done) begin
                step_cnt  <= '0;
                cur_floor <= next_floor;
                if (stop_here) begin
                  motor_en   <= 1'b0;
                  door_open  <= 1'b1;
                  door_timer <= '0;
                  state      <= DOOR;
                end
              end else begin
                step_cnt <= step_cnt + 1'b1;
              end
            end else begin
              step_timer <= step_timer + 1'b1;
            end
          end
        end
        DOOR: begin
          if (!halt) begin
            if (door_restart) begin
              door_timer <= '0;
            end else if (door_done) begin
              door_timer <= '0;
              door_open  <= 1'b0;
              state      <= IDLE;
            end else begin
              door_timer <= door_timer + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
